// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N-channel W-bit multiplexer with manual select and auto-scan
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         N*W packed channels, channel k = in[k*W +: W]
//   sel        manual channel select
//   mode       0 = manual, 1 = auto-scan
//   en         block enable
//   dwell      scan dwell; each channel is presented dwell+1 cycles
//   out        registered selected data
//   out_sel    channel index that produced out
//   out_valid  out/out_sel valid this cycle
//   wrap       one-cycle pulse on the first output of channel 0 after a full sweep
//   sel_err    registered flag: manual sel >= N
module scan_mux #(
    parameter int W    = 8,
    parameter int N    = 8,
    parameter int SELW = $clog2(N),
    parameter int DWW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    input  logic [DWW-1:0]  dwell,
    output logic [W-1:0]    out,
    output logic [SELW-1:0] out_sel,
    output logic            out_valid,
    output logic            wrap,
    output logic            sel_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST  = SELW'(N - 1);

    state_t state, state_nxt;

    logic [SELW-1:0] ch;
    logic [DWW-1:0]  dc;
    // Set on the edge where the scan index wraps to 0; turned into the
    // wrap pulse on the following edge so it lines up with out_sel == 0.
    logic            wrapped;

    // Channel table padded to the full select range; unused slots read 0 so
    // an out-of-range manual select naturally produces out = 0.
    logic [W-1:0] chan [2**SELW];

    for (genvar k = 0; k < 2**SELW; k++) begin : g_chan
        if (k < N) begin : g_used
            assign chan[k] = in[k*W +: W];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (en) begin
            state_nxt = mode ? SCAN : MANUAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            sel_err   <= 1'b0;
            ch        <= '0;
            dc        <= '0;
            wrapped   <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            wrap    <= 1'b0;
            wrapped <= 1'b0;
            case (state)
                MANUAL: begin
                    out       <= chan[sel];
                    out_sel   <= sel;
                    out_valid <= 1'b1;
                    sel_err   <= ({1'b0, sel} >= N_EXT);
                    // Scan progress is dropped; the next SCAN entry starts at 0.
                    ch        <= '0;
                    dc        <= '0;
                end
                SCAN: begin
                    out       <= chan[ch];
                    out_sel   <= ch;
                    out_valid <= 1'b1;
                    wrap      <= wrapped;
                    // >= so that lowering dwell below dc advances immediately.
                    if (dc >= dwell) begin
                        dc <= '0;
                        if (ch == LAST) begin
                            ch      <= '0;
                            wrapped <= 1'b1;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end else begin
                        dc <= dc + 1'b1;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    ch        <= '0;
                    dc        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - self-checking bench for scan_mux
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, mode;
    logic [2:0]  sel8;
    logic [7:0]  dwell;
    logic [63:0] in8;
    logic [31:0] in4;
    logic [39:0] in5;

    logic [7:0] out8, out4, out5;
    logic [2:0] osel8, osel5;
    logic [1:0] osel4;
    logic       v8, v4, v5, w8, w4, w5, e8, e4, e5;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_mux #(.W(8), .N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .mode(mode), .en(en),
        .dwell(dwell), .out(out8), .out_sel(osel8), .out_valid(v8), .wrap(w8),
        .sel_err(e8)
    );

    scan_mux #(.W(8), .N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel8[1:0]), .mode(mode), .en(en),
        .dwell(dwell), .out(out4), .out_sel(osel4), .out_valid(v4), .wrap(w4),
        .sel_err(e4)
    );

    scan_mux #(.W(8), .N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .in(in5), .sel(sel8), .mode(mode), .en(en),
        .dwell(dwell), .out(out5), .out_sel(osel5), .out_valid(v5), .wrap(w5),
        .sel_err(e5)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] dwell;
        logic [7:0] eout;
        logic [2:0] esel;
        logic       evalid;
        logic       ewrap;
    } vec_t;

    vec_t tbl [29];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel8  = '0;
        dwell = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) in8[k*8 +: 8] = 8'(k * 17);
        for (int k = 0; k < 5; k++) in5[k*8 +: 8] = 8'(8'hA0 + k);
        in4 = '0;

        //            en mode sel dwell  eout  esel v  w
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'd0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 8'd0, 8'h00, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 8'd0, 8'h00, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 8'd0, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd1, 8'd0, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd3, 8'd0, 8'h33, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd3, 8'd0, 8'h33, 3'd3, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd2, 8'd0, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'd2, 8'd0, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 3'd2, 8'd0, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 3'd2, 8'd0, 8'h22, 3'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 3'd2, 8'd0, 8'h22, 3'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'd5, 8'd0, 8'h22, 3'd2, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'd5, 8'd0, 8'h55, 3'd5, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h55, 3'd5, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h00, 3'd0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h33, 3'd3, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h44, 3'd4, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h55, 3'd5, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h66, 3'd6, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h77, 3'd7, 1'b1, 1'b0};
        tbl[23] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h00, 3'd0, 1'b1, 1'b1};
        tbl[24] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[25] = '{1'b1, 1'b1, 3'd5, 8'd5, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[26] = '{1'b1, 1'b1, 3'd5, 8'd5, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[27] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[28] = '{1'b1, 1'b1, 3'd5, 8'd0, 8'h33, 3'd3, 1'b1, 1'b0};

        // Reset state, checked while reset is still held.
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel8  = '0;
        dwell = '0;
        @(posedge clk);
        #1;
        chk("rst_out", 32'(out8), 32'h0);
        chk("rst_out_sel", 32'(osel8), 32'h0);
        chk("rst_valid", 32'(v8), 32'h0);
        chk("rst_wrap", 32'(w8), 32'h0);
        chk("rst_sel_err", 32'(e8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual sweep, enable drop, manual->scan switch, dwell=0 scan, dwell lowering.
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            en    = tbl[i].en;
            mode  = tbl[i].mode;
            sel8  = tbl[i].sel;
            dwell = tbl[i].dwell;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out", i), 32'(out8), 32'(tbl[i].eout));
            chk($sformatf("tbl%0d_out_sel", i), 32'(osel8), 32'(tbl[i].esel));
            chk($sformatf("tbl%0d_valid", i), 32'(v8), 32'(tbl[i].evalid));
            chk($sformatf("tbl%0d_wrap", i), 32'(w8), 32'(tbl[i].ewrap));
            chk($sformatf("tbl%0d_sel_err", i), 32'(e8), 32'h0);
        end

        // N=4, dwell=2 scan with live input data changing every cycle.
        do_reset();
        @(negedge clk);
        en = 1'b1; mode = 1'b1; dwell = 8'd2;
        @(posedge clk);
        #1;
        chk("n4_first_valid", 32'(v4), 32'h0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) in4[k*8 +: 8] = {4'(i), 4'(k)};
            @(posedge clk);
            #1;
            chk($sformatf("n4_c%0d_out_sel", i), 32'(osel4), 32'((i / 3) % 4));
            chk($sformatf("n4_c%0d_out", i), 32'(out4), 32'({4'(i), 4'((i / 3) % 4)}));
            chk($sformatf("n4_c%0d_wrap", i), 32'(w4), 32'((i != 0) && (i % 12 == 0)));
            chk($sformatf("n4_c%0d_valid", i), 32'(v4), 32'h1);
        end

        // N=5, out-of-range manual select.
        do_reset();
        @(negedge clk);
        en = 1'b1; mode = 1'b0; sel8 = 3'd6;
        repeat (2) @(posedge clk);
        #1;
        chk("n5_bad_out", 32'(out5), 32'h0);
        chk("n5_bad_sel_err", 32'(e5), 32'h1);
        chk("n5_bad_valid", 32'(v5), 32'h1);
        chk("n5_bad_out_sel", 32'(osel5), 32'h6);
        @(negedge clk);
        sel8 = 3'd4;
        @(posedge clk);
        #1;
        chk("n5_ok_out", 32'(out5), 32'hA4);
        chk("n5_ok_sel_err", 32'(e5), 32'h0);
        chk("n5_ok_out_sel", 32'(osel5), 32'h4);

        // Asynchronous reset mid-scan, then restart from channel 0.
        do_reset();
        @(negedge clk);
        en = 1'b1; mode = 1'b1; dwell = 8'd1;
        begin
            logic found;
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(posedge clk);
                #1;
                if (osel8 == 3'd3) found = 1'b1;
            end
            chk("ar_reach_ch3", 32'(found), 32'h1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out", 32'(out8), 32'h0);
        chk("ar_out_sel", 32'(osel8), 32'h0);
        chk("ar_valid", 32'(v8), 32'h0);
        chk("ar_wrap", 32'(w8), 32'h0);
        chk("ar_sel_err", 32'(e8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_rel_valid", 32'(v8), 32'h0);
        @(posedge clk);
        #1;
        chk("ar_rel_out_sel0", 32'(osel8), 32'h0);
        chk("ar_rel_valid1", 32'(v8), 32'h1);
        @(posedge clk);
        #1;
        chk("ar_rel_out_sel0b", 32'(osel8), 32'h0);
        @(posedge clk);
        #1;
        chk("ar_rel_out_sel1", 32'(osel8), 32'h1);
        chk("ar_rel_out1", 32'(out8), 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
